regfile_wb_ctrl: RTL
====================

# regfile_wb_ctrl

Write-back controller for the single-write-port integer register file. It arbitrates between the ALU result path and the load-data path, drives the register file's write port through a registered stage, suppresses writes to x0, and keeps a scoreboard of registers with outstanding loads so decode can stall on read-after-load hazards.

## Interface
Parameters:
- NUM_REG, 32, number of architectural registers
- REG_ADDR_WIDTH, 5, register index width (log2 of NUM_REG)
- REG_WIDTH, 32, data width

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- alu_valid  input  1  ALU write-back request
- alu_rd  input  REG_ADDR_WIDTH  ALU destination register
- alu_data  input  REG_WIDTH  ALU result
- alu_ready  output  1  ALU request accepted this cycle
- mem_valid  input  1  load write-back request
- mem_rd  input  REG_ADDR_WIDTH  load destination register
- mem_data  input  REG_WIDTH  load data
- mem_ready  output  1  load request accepted this cycle
- ld_issue  input  1  a load is issued this cycle (marks rd pending)
- ld_issue_rd  input  REG_ADDR_WIDTH  destination of the issued load
- chk_rs1, chk_rs2  input  REG_ADDR_WIDTH  source registers being decoded
- stall  output  1  chk_rs1 or chk_rs2 has a pending load
- rf_we  output  1  register file write enable
- rf_addr  output  REG_ADDR_WIDTH  register file write address
- rf_data  output  REG_WIDTH  register file write data

## Operation
- Handshake: transfer on valid && ready. Requester holds valid, rd and data stable until ready. ready is combinational from valid and the arbiter state. Only one source is granted per cycle.
- Arbitration is round-robin with a 1-bit last_grant register:
  - If only one source is valid, that source is granted.
  - If both are valid, the source not in last_grant is granted.
  - last_grant updates on every transfer.
- Output stage: on a transfer, rf_addr and rf_data load from the granted source on the next clock edge. rf_we = 1 for exactly that one cycle, except when rd == 0. In that case the transfer still completes, but rf_we stays 0. The register file has no hardwired x0, so this rule is mandatory.
- Scoreboard: NUM_REG-bit vector named pending.
  - ld_issue with ld_issue_rd != 0 sets pending[ld_issue_rd]. Issues to rd 0 are ignored.
  - A mem transfer clears pending[mem_rd].
  - If a set and a clear hit the same index in the same cycle, set wins. The new load is outstanding.
  - ALU transfers do not touch pending.
- stall = pending[chk_rs1] | pending[chk_rs2]. It is combinational and uses the registered pending only; there is no bypass of same-cycle clears. Index 0 never stalls.

## Timing
- Reset values: rf_we 0, rf_addr 0, rf_data 0, pending all 0, last_grant = MEM (ALU wins the first contention), stall 0.
- Latency: transfer at edge N produces rf_we/rf_addr/rf_data valid during cycle N+1. The register file captures at edge N+1.
- Throughput: one write-back per cycle, sustained. Back-to-back transfers give back-to-back rf_we pulses.
- Contention: both sources held valid alternate every cycle, ALU first after reset.
- pending clears at the same edge the mem transfer occurs, so stall drops in cycle N+1. This is the cycle the write reaches the register file. Decode reads after that edge see the new value.
- Reset asserted mid-operation: all state clears immediately. An in-flight rf_we is dropped, and no partial write occurs after rst_n deasserts. Requesters must re-present.

## Configuration
- Macro WBCTRL_MEM_PRIORITY_EN.
- Defined: fixed priority; mem always wins when both are valid, and last_grant is not implemented.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; the cycle after, rf_we=0.
- Both valid continuously for 4 cycles (alu_rd=1, mem_rd=2) -> grants ALU, MEM, ALU, MEM; rf_addr sequence 1,2,1,2 with rf_we=1 each cycle. With WBCTRL_MEM_PRIORITY_EN: MEM granted 4 times, alu_ready=0 throughout.
- alu_rd=0, alu_data=0x1234, alu_valid=1 -> alu_ready=1, rf_we stays 0.
- ld_issue with rd=7; next cycle chk_rs1=7 -> stall=1; mem transfer rd=7 -> stall=0 the following cycle, with rf_we=1, rf_addr=7.
- Same cycle: mem transfer rd=9 and ld_issue rd=9 -> pending[9] stays 1, and chk_rs2=9 gives stall=1.
- Transfer at edge N, then rst_n low during cycle N+1 -> rf_we=0 immediately, pending cleared, no write after release.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Write-back controller for the single-write-port integer register file.
// It picks one of two write-back sources each cycle (ALU result or load
// data) and registers the chosen write onto the register file port. Writes
// to x0 are suppressed because the register file has no hardwired zero.
// It also tracks registers that have a load in flight, so decode can stall
// on read-after-load hazards.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   alu_valid/alu_rd/alu_data       ALU write-back request
//   alu_ready                       ALU request accepted this cycle
//   mem_valid/mem_rd/mem_data       load write-back request
//   mem_ready                       load request accepted this cycle
//   ld_issue/ld_issue_rd            a load is issued; marks its rd pending
//   chk_rs1/chk_rs2                 source registers being decoded
//   stall                           a decoded source has a pending load
//   rf_we/rf_addr/rf_data           registered register-file write port
//
// Configuration:
//   WBCTRL_MEM_PRIORITY_EN  defined   -> mem always wins when both are valid
//                           undefined -> round-robin using last_grant
module regfile_wb_ctrl #(
  parameter int NUM_REG        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]      alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [REG_WIDTH-1:0]      mem_data,
  output logic                      mem_ready,
  input  logic                      ld_issue,
  input  logic [REG_ADDR_WIDTH-1:0] ld_issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
  output logic                      stall,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [REG_WIDTH-1:0]      rf_data
);

  logic grant_alu;
  logic grant_mem;

  logic                      rf_we_q,   rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [REG_WIDTH-1:0]      rf_data_q, rf_data_d;
  logic [NUM_REG-1:0]        pending_q, pending_d;

`ifdef WBCTRL_MEM_PRIORITY_EN

  // Fixed priority: the load path always wins, ALU only gets idle slots.
  always_comb begin
    grant_mem = mem_valid;
    grant_alu = alu_valid && !mem_valid;
  end

`else

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  src_e last_grant_q, last_grant_d;

  // Round-robin: on contention the source that did not win last time is
  // granted. last_grant resets to MEM so the ALU wins the first contention.
  always_comb begin
    grant_alu    = 1'b0;
    grant_mem    = 1'b0;
    last_grant_d = last_grant_q;
    if (alu_valid && mem_valid) begin
      if (last_grant_q == SRC_MEM) grant_alu = 1'b1;
      else                         grant_mem = 1'b1;
    end else begin
      grant_alu = alu_valid;
      grant_mem = mem_valid;
    end
    if (grant_alu)      last_grant_d = SRC_ALU;
    else if (grant_mem) last_grant_d = SRC_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= SRC_MEM;
    else        last_grant_q <= last_grant_d;
  end

`endif

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Output stage and scoreboard next-state. The address and data load on
  // every transfer, including rd 0, but the write enable is withheld for rd 0.
  // In the scoreboard the clear is applied before the set, so a new load
  // issued to the same register in the same cycle stays outstanding.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    pending_d = pending_q;
    if (grant_alu) begin
      rf_we_d   = (alu_rd != '0);
      rf_addr_d = alu_rd;
      rf_data_d = alu_data;
    end else if (grant_mem) begin
      rf_we_d   = (mem_rd != '0);
      rf_addr_d = mem_rd;
      rf_data_d = mem_data;
    end
    if (grant_mem) pending_d[mem_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != '0)) pending_d[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      pending_q <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      pending_q <= pending_d;
    end
  end

  // Only the registered scoreboard is consulted, so a clear takes effect
  // one cycle later, exactly when the write reaches the register file.
  // Bit 0 is never set, so x0 never stalls.
  assign stall   = pending_q[chk_rs1] | pending_q[chk_rs2];
  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

endmodule
